mem_arbiter_n: RTL and testbench
================================

Name: mem_arbiter_n

Overview:
- Parametrised N-port memory request arbiter between core memory clients (D$, I$, MMUs, optional extra masters) and the single shared memory master port.
- Round-robin grant with a grant lock held across the memory handshake.
- Per-port outstanding-read-word credit tracking, with back-pressure when a port's credit would be exceeded.
- Response demultiplexing by ID, and a sticky protocol-error flag.

Parameters:
- NUM_PORTS, 4, number of client ports (2..16); port 0 has the lowest priority index.
- ID_W, $clog2(NUM_PORTS), width of the memory ID; derived, do not override.
- RLEN_W, 5, burst-length field width; a read returns rlen+1 words.
- MAX_RD_WORDS, 32, per-port cap on read words in flight; must be >= 2^RLEN_W.
- WRITE_MASK, 'b1, bit i set means port i may issue writes/RMW; on other ports rnw is forced 1 and rmw forced 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- p_request  in  NUM_PORTS  per-port request, held until p_ack
- p_addr  in  NUM_PORTS*30  word address [31:2] per port
- p_rlen  in  NUM_PORTS*RLEN_W  per-port burst length minus one
- p_rnw  in  NUM_PORTS  1 = read
- p_rmw  in  NUM_PORTS  read-modify-write
- p_wbe  in  NUM_PORTS*4  write byte enables
- p_wdata  in  NUM_PORTS*32  write data
- p_ack  out  NUM_PORTS  per-port accept
- p_rvalid  out  NUM_PORTS  per-port read-data valid
- p_rdata  out  32  shared read data (mem_rdata)
- mem_request  out  1  request to memory
- mem_ack  in  1  memory accept
- mem_addr  out  30  selected address
- mem_rlen  out  RLEN_W  selected rlen
- mem_rnw / mem_rmw  out  1 each  selected rnw / rmw
- mem_wbe  out  4  selected wbe
- mem_wdata  out  32  selected wdata
- mem_id  out  ID_W  grantee index
- mem_rvalid  in  1  read beat valid
- mem_rid  in  ID_W  read beat ID
- mem_rdata  in  32  read beat data
- rd_err  out  1  sticky error flag
- perf_grants  out  NUM_PORTS*32  grant counters (see Optional Feature)

Behaviour:
- Reset (async, rst high): rr pointer = NUM_PORTS-1 (port 0 highest priority next), lock cleared, all credit counters 0, rd_err 0, perf counters 0.
- Eligibility: port i is eligible when p_request[i] is set and it is either a write (rnw=0, allowed by WRITE_MASK) or cnt[i]+rlen+1 <= MAX_RD_WORDS. RMW counts as a read.
- mem_request = any port eligible, or lock set.
- Grantee selection, unlocked: first eligible port searching from pointer+1, wrapping modulo NUM_PORTS. The choice is combinational, so a grant is possible in the same cycle as the request.
- Locked: the grantee is the registered locked port, regardless of new requests.
- Lock rule:
  - If mem_request=1 and mem_ack=0, lock is set to the current grantee next cycle.
  - Lock clears on mem_ack.
  - The grantee's mux selection and credit check are frozen while locked.
- On mem_request & mem_ack: p_ack[grantee]=1 (combinational), pointer <= grantee, lock cleared.
- mem_addr, mem_rlen, mem_rnw, mem_rmw, mem_wbe, mem_wdata and mem_id are all muxed from the grantee; mem_id = grantee.
- Credits, cnt[i] width $clog2(MAX_RD_WORDS+1):
  - +(rlen+1) on an accepted read to port i.
  - -1 per mem_rvalid with mem_rid=i.
  - Same-cycle accept and beat on one port: net +rlen.
- Response routing: p_rvalid[i] = mem_rvalid & (mem_rid==i). An rid >= NUM_PORTS routes nowhere and sets rd_err.
- rd_err also sets on mem_rvalid for a port whose cnt is 0; that counter saturates at 0. rd_err clears only on rst.
- Single active request: granted with zero added latency. No starvation: each eligible requester is granted within NUM_PORTS grants.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: perf_grants holds per-port 32-bit counters, +1 on every accepted grant to that port, wrapping at 2^32, reset to 0.
- Undefined: no counter flops; perf_grants tied 0.

Test Plan:
- Reset, then NUM_PORTS=4, all four ports request reads with rlen=0, mem_ack always 1 -> mem_id sequence 0,1,2,3,0; each p_ack pulses once per four cycles.
- Port 2 read rlen=3, mem_ack held 0 for 3 cycles while port 0 requests -> mem_id stays 2 and mem_addr is stable until ack; port 0 is granted on the next cycle.
- MAX_RD_WORDS=32: port 1 issues 8 reads with rlen=3 and no rvalid -> cnt=32, 9th request not eligible; after one rvalid rid=1 it stays blocked until 4 beats return.
- Port 3 with WRITE_MASK bit 3=0 drives rnw=0 -> mem_rnw=1, mem_rmw=0; port 0 write with wbe=4'b0011 passes through without credit change.
- mem_rvalid with rid=1 while cnt[1]=0 -> rd_err=1, p_rvalid[1]=1, cnt stays 0; rd_err persists until rst.
- With MEM_ARB_PERF_EN, 5 grants to port 0 then async rst mid-transfer -> perf_grants[0] reads 5 before reset; all outputs return to reset values immediately on rst.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port round-robin memory arbiter with grant lock, read credits, ID-routed responses; MEM_ARB_PERF_EN adds grant counters
module mem_arbiter_n #(
   parameter int NUM_PORTS = 4,
   parameter int ID_W = $clog2(NUM_PORTS),
   parameter int RLEN_W = 5,
   parameter int MAX_RD_WORDS = 32,
   parameter logic [15:0] WRITE_MASK = 16'h1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        p_request,
   input  logic [NUM_PORTS*30-1:0]     p_addr,
   input  logic [NUM_PORTS*RLEN_W-1:0] p_rlen,
   input  logic [NUM_PORTS-1:0]        p_rnw,
   input  logic [NUM_PORTS-1:0]        p_rmw,
   input  logic [NUM_PORTS*4-1:0]      p_wbe,
   input  logic [NUM_PORTS*32-1:0]     p_wdata,
   output logic [NUM_PORTS-1:0]        p_ack,
   output logic [NUM_PORTS-1:0]        p_rvalid,
   output logic [31:0]                 p_rdata,
   output logic                        mem_request,
   input  logic                        mem_ack,
   output logic [29:0]                 mem_addr,
   output logic [RLEN_W-1:0]           mem_rlen,
   output logic                        mem_rnw,
   output logic                        mem_rmw,
   output logic [3:0]                  mem_wbe,
   output logic [31:0]                 mem_wdata,
   output logic [ID_W-1:0]             mem_id,
   input  logic                        mem_rvalid,
   input  logic [ID_W-1:0]             mem_rid,
   input  logic [31:0]                 mem_rdata,
   output logic                        rd_err,
   output logic [NUM_PORTS*32-1:0]     perf_grants
);
   localparam int CW = $clog2(MAX_RD_WORDS + 1);
   logic [29:0]          addr_a  [NUM_PORTS];
   logic [RLEN_W-1:0]    rlen_a  [NUM_PORTS];
   logic [3:0]           wbe_a   [NUM_PORTS];
   logic [31:0]          wdata_a [NUM_PORTS];
   logic [CW-1:0]        cnt     [NUM_PORTS];
   logic [NUM_PORTS-1:0] rnw_e, rmw_e, elig, zero_hit;
   logic [ID_W-1:0]      ptr, lock_id, pick, grant;
   logic                 locked, found, accept, err_set;
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic take, beat;
      assign addr_a[i]   = p_addr[30*i +: 30];
      assign rlen_a[i]   = p_rlen[RLEN_W*i +: RLEN_W];
      assign wbe_a[i]    = p_wbe[4*i +: 4];
      assign wdata_a[i]  = p_wdata[32*i +: 32];
      assign rnw_e[i]    = p_rnw[i] | ~WRITE_MASK[i];
      assign rmw_e[i]    = p_rmw[i] & WRITE_MASK[i];
      assign elig[i]     = p_request[i] & (~(rnw_e[i] | rmw_e[i]) |
                           ({1'b0, cnt[i]} + (CW+1)'(rlen_a[i]) + (CW+1)'(1) <= (CW+1)'(MAX_RD_WORDS)));
      assign p_rvalid[i] = mem_rvalid & (mem_rid == ID_W'(i));
      assign zero_hit[i] = p_rvalid[i] & (cnt[i] == '0);
      assign take        = accept & (grant == ID_W'(i)) & (rnw_e[i] | rmw_e[i]);
      assign beat        = p_rvalid[i] & (cnt[i] != '0);
      // read words in flight: add the burst on accept, retire one per returned beat, never below zero
      always_ff @(posedge clk or posedge rst)
         if (rst) cnt[i] <= '0;
         else cnt[i] <= cnt[i] + (take ? CW'(rlen_a[i]) + CW'(1) : '0) - CW'(beat);
   end
   // first eligible port after the last grantee, wrapping
   always_comb begin
      pick = ptr;
      found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++)
         if (!found && elig[(int'(ptr) + k) % NUM_PORTS]) begin
            found = 1'b1;
            pick = ID_W'((int'(ptr) + k) % NUM_PORTS);
         end
   end
   assign grant       = locked ? lock_id : pick;
   assign mem_request = found | locked;
   assign accept      = mem_request & mem_ack;
   assign p_ack       = accept ? NUM_PORTS'(1) << grant : '0;
   assign mem_id      = grant;
   assign mem_addr    = addr_a[grant];
   assign mem_rlen    = rlen_a[grant];
   assign mem_rnw     = rnw_e[grant];
   assign mem_rmw     = rmw_e[grant];
   assign mem_wbe     = wbe_a[grant];
   assign mem_wdata   = wdata_a[grant];
   assign p_rdata     = mem_rdata;
   assign err_set     = mem_rvalid & (~|p_rvalid | |zero_hit);
   // pointer follows each accepted grant; an unaccepted request pins the grantee until memory takes it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ptr <= ID_W'(NUM_PORTS - 1);
         locked <= 1'b0;
         lock_id <= '0;
      end else if (accept) begin
         ptr <= grant;
         locked <= 1'b0;
      end else if (mem_request) begin
         locked <= 1'b1;
         lock_id <= grant;
      end
   // sticky flag for beats with an unknown ID or no words outstanding
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_err <= 1'b0;
      else if (err_set) rd_err <= 1'b1;
`ifdef MEM_ARB_PERF_EN
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_perf
      logic [31:0] n;
      // accepted grants per port, wrapping
      always_ff @(posedge clk or posedge rst)
         if (rst) n <= '0;
         else if (accept && grant == ID_W'(i)) n <= n + 32'd1;
      assign perf_grants[32*i +: 32] = n;
   end
`else
   assign perf_grants = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed and randomized checks of mem_arbiter_n against a cycle-level reference model
module tb_mem_arbiter_n;
   localparam int N = 4, RW = 5, MAXW = 32;
   localparam logic [15:0] WM = 16'h1;
`ifdef MEM_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] p_request = '0, p_rnw = '0, p_rmw = '0;
   logic [N*30-1:0] p_addr = '0;
   logic [N*RW-1:0] p_rlen = '0;
   logic [N*4-1:0] p_wbe = '0;
   logic [N*32-1:0] p_wdata = '0;
   logic [N-1:0] p_ack, p_rvalid;
   logic [31:0] p_rdata, mem_wdata, mem_rdata = '0;
   logic mem_request, mem_ack = 1'b0, mem_rnw, mem_rmw, mem_rvalid = 1'b0, rd_err;
   logic [29:0] mem_addr;
   logic [RW-1:0] mem_rlen;
   logic [3:0] mem_wbe;
   logic [1:0] mem_id, mem_rid = '0;
   logic [N*32-1:0] perf_grants;
   int n_chk = 0, n_pass = 0;
   int m_last, m_lock, m_cnt[N], m_grants[N];
   bit m_err;
   int e_g;
   bit e_acc;

   mem_arbiter_n #(.NUM_PORTS(N), .RLEN_W(RW), .MAX_RD_WORDS(MAXW), .WRITE_MASK(WM)) dut (
      .clk(clk), .rst(rst), .p_request(p_request), .p_addr(p_addr), .p_rlen(p_rlen),
      .p_rnw(p_rnw), .p_rmw(p_rmw), .p_wbe(p_wbe), .p_wdata(p_wdata), .p_ack(p_ack),
      .p_rvalid(p_rvalid), .p_rdata(p_rdata), .mem_request(mem_request), .mem_ack(mem_ack),
      .mem_addr(mem_addr), .mem_rlen(mem_rlen), .mem_rnw(mem_rnw), .mem_rmw(mem_rmw),
      .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_id(mem_id), .mem_rvalid(mem_rvalid),
      .mem_rid(mem_rid), .mem_rdata(mem_rdata), .rd_err(rd_err), .perf_grants(perf_grants));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic bit is_rd(int i);
      return !WM[i] || p_rnw[i] || p_rmw[i];
   endfunction

   function automatic int words(int i);
      return int'(p_rlen[i*RW +: RW]) + 1;
   endfunction

   function automatic int pick();
      if (m_lock >= 0) return m_lock;
      for (int k = 1; k <= N; k++) begin
         int j = (m_last + k) % N;
         if (p_request[j] && (!is_rd(j) || m_cnt[j] + words(j) <= MAXW)) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last = N - 1;
      m_lock = -1;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         m_grants[i] = 0;
      end
   endtask

   task automatic settle();
      #1;
      e_g = pick();
      e_acc = e_g >= 0 && mem_ack;
      check("req", mem_request, e_g >= 0);
      if (e_g >= 0) begin
         check("id", mem_id, e_g);
         check("addr", mem_addr, p_addr[e_g*30 +: 30]);
         check("rlen", mem_rlen, p_rlen[e_g*RW +: RW]);
         check("rnw", mem_rnw, !WM[e_g] || p_rnw[e_g]);
         check("rmw", mem_rmw, WM[e_g] && p_rmw[e_g]);
         check("wbe", mem_wbe, p_wbe[e_g*4 +: 4]);
         check("wdata", mem_wdata, p_wdata[e_g*32 +: 32]);
      end
      check("ack", p_ack, e_acc ? (1 << e_g) : 0);
      check("rvalid", p_rvalid, mem_rvalid ? (1 << mem_rid) : 0);
      check("rdata", p_rdata, mem_rdata);
      check("err", rd_err, m_err);
      for (int i = 0; i < N; i++) check("perf", perf_grants[i*32 +: 32], PERF ? 32'(m_grants[i]) : 32'd0);
   endtask

   task automatic advance();
      @(posedge clk);
      if (mem_rvalid) begin
         if (m_cnt[mem_rid] == 0) m_err = 1'b1;
         else m_cnt[mem_rid]--;
      end
      if (e_acc) begin
         m_last = e_g;
         m_lock = -1;
         m_grants[e_g]++;
         if (is_rd(e_g)) m_cnt[e_g] += words(e_g);
      end else if (e_g >= 0) m_lock = e_g;
      @(negedge clk);
   endtask

   task automatic do_reset();
      p_request = '0;
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_port(int i, bit rnw, bit rmw, int rlen, logic [29:0] a, logic [3:0] be, logic [31:0] d);
      p_request[i] = 1'b1;
      p_rnw[i] = rnw;
      p_rmw[i] = rmw;
      p_rlen[i*RW +: RW] = RW'(rlen);
      p_addr[i*30 +: 30] = a;
      p_wbe[i*4 +: 4] = be;
      p_wdata[i*32 +: 32] = d;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      settle();
      check("rst_req", mem_request, 0);
      check("rst_err", rd_err, 0);
      advance();
      // round robin, all ports reading single words, memory always ready
      for (int i = 0; i < N; i++) set_port(i, 1, 0, 0, 30'(100 + i), 4'hf, 32'(i));
      mem_ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         check("rr_id", mem_id, k % N);
         check("rr_ack", p_ack, 1 << (k % N));
         advance();
      end
      // port 2 held by the lock while port 0 waits
      p_request = '0;
      set_port(2, 1, 0, 3, 30'h2aaa, 4'hf, 32'h0);
      set_port(0, 1, 0, 0, 30'h1111, 4'hf, 32'h0);
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("lk_id", mem_id, 2);
         check("lk_addr", mem_addr, 30'h2aaa);
         advance();
      end
      mem_ack = 1'b1;
      settle();
      check("lk_ack", p_ack, 4'b0100);
      advance();
      p_request[2] = 1'b0;
      settle();
      check("lk_next", mem_id, 0);
      check("lk_next_ack", p_ack, 4'b0001);
      advance();
      // credit exhaustion on port 1
      do_reset();
      set_port(1, 1, 0, 3, 30'h55, 4'hf, 32'h0);
      mem_ack = 1'b1;
      for (int k = 0; k < 8; k++) begin
         settle();
         check("cr_ack", p_ack, 4'b0010);
         advance();
      end
      settle();
      check("cr_block", mem_request, 0);
      advance();
      for (int b = 1; b <= 4; b++) begin
         mem_rvalid = 1'b1;
         mem_rid = 2'd1;
         mem_rdata = $urandom;
         settle();
         advance();
         mem_rvalid = 1'b0;
         settle();
         check("cr_after", mem_request, b == 4);
      end
      advance();
      p_request = '0;
      // write mask: port 3 forced to plain read, port 0 writes pass through
      set_port(3, 0, 1, 2, 30'h333, 4'h5, 32'hdead_beef);
      settle();
      check("wm_rnw", mem_rnw, 1);
      check("wm_rmw", mem_rmw, 0);
      advance();
      p_request = '0;
      set_port(0, 0, 0, 7, 30'h444, 4'b0011, 32'hcafe_f00d);
      settle();
      check("wr_rnw", mem_rnw, 0);
      check("wr_wbe", mem_wbe, 4'b0011);
      check("wr_id", mem_id, 0);
      advance();
      p_request = '0;
      // beat for a port with nothing outstanding
      do_reset();
      mem_rvalid = 1'b1;
      mem_rid = 2'd1;
      settle();
      check("er_rv", p_rvalid, 4'b0010);
      advance();
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("er_sticky", rd_err, 1);
         advance();
      end
      // five grants to port 0, then asynchronous reset while port 0 is locked
      set_port(0, 1, 0, 0, 30'h10, 4'hf, 32'h0);
      mem_ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         advance();
      end
      mem_ack = 1'b0;
      settle();
      check("pf_cnt", perf_grants[31:0], PERF ? 32'd5 : 32'd0);
      advance();
      rst = 1'b1;
      p_request = '0;
      #1;
      check("ar_err", rd_err, 0);
      check("ar_perf", perf_grants, '0);
      check("ar_req", mem_request, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!p_request[i] && $urandom_range(2) == 0)
               set_port(i, $urandom_range(3) != 0, $urandom_range(3) == 0,
                        $urandom_range(9) == 0 ? 31 : int'($urandom_range(7)),
                        30'($urandom), 4'($urandom), $urandom);
         mem_ack = $urandom_range(3) != 0;
         mem_rvalid = 1'b0;
         if ($urandom_range(1) == 0) begin
            int j = int'($urandom_range(N - 1));
            if (m_cnt[j] > 0) begin
               mem_rvalid = 1'b1;
               mem_rid = 2'(j);
            end
         end
         mem_rdata = $urandom;
         settle();
         advance();
         if (e_acc) p_request[e_g] = 1'b0;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
